// File: rtl/multi_edge_catcher.sv
// Multi-channel synchroniser, debouncer and edge-to-pulse catcher.
// Optional auto-repeat of held inputs is enabled by defining MULTI_EDGE_CATCHER_REPEAT_EN.
module multi_edge_catcher #(
  parameter int unsigned CHANNELS        = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_MODE       = 0,
  parameter int unsigned REPEAT_DELAY    = 1000,
  parameter int unsigned REPEAT_PERIOD   = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] channel_en,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] level,
  output logic                any_out
);

  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [DCW-1:0]      db_cnt_q [CHANNELS];
  logic [DCW-1:0]      db_cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                any_q;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] edge_hit;
  logic [CHANNELS-1:0] rep_hit;

  assign s       = sync_q[SYNC_STAGES-1];
  assign out     = out_q;
  assign level   = level_q;
  assign any_out = any_q;

  always_comb begin
    level_d  = level_q;
    accept   = '0;
    edge_hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (s[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
        accept[i]   = 1'b1;
        level_d[i]  = s[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
      if (EDGE_MODE == 2) begin
        edge_hit[i] = accept[i];
      end else if (EDGE_MODE == 1) begin
        edge_hit[i] = accept[i] & ~s[i];
      end else begin
        edge_hit[i] = accept[i] & s[i];
      end
    end
  end

  // The enable masks only newly generated pulses; a registered pulse always completes.
  assign out_d = channel_en & (edge_hit | rep_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        db_cnt_q[i] <= '0;
      end
      level_q <= '0;
      out_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      sync_q[0] <= in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      level_q <= level_d;
      out_q   <= out_d;
      any_q   <= |out_d;
    end
  end

`ifdef MULTI_EDGE_CATCHER_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCW  = $clog2(RMAX + 1);
  localparam logic ACTIVE_LVL  = (EDGE_MODE == 1) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_PERIOD
  } rpt_state_e;

  rpt_state_e     rpt_q     [CHANNELS];
  rpt_state_e     rpt_d     [CHANNELS];
  logic [RCW-1:0] rpt_cnt_q [CHANNELS];
  logic [RCW-1:0] rpt_cnt_d [CHANNELS];

  // Arming happens only on an accepted edge into the active level, so an idle
  // channel sitting at the active level after reset never auto-repeats.
  always_comb begin
    rep_hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      rpt_d[i]     = rpt_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (accept[i]) begin
        rpt_cnt_d[i] = '0;
        rpt_d[i]     = (s[i] == ACTIVE_LVL) ? RPT_DELAY : RPT_IDLE;
      end else if (rpt_q[i] != RPT_IDLE) begin
        if ((rpt_q[i] == RPT_DELAY  && rpt_cnt_q[i] == RCW'(REPEAT_DELAY - 1)) ||
            (rpt_q[i] == RPT_PERIOD && rpt_cnt_q[i] == RCW'(REPEAT_PERIOD - 1))) begin
          rep_hit[i]   = 1'b1;
          rpt_cnt_d[i] = '0;
          rpt_d[i]     = RPT_PERIOD;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        rpt_q[i]     <= RPT_IDLE;
        rpt_cnt_q[i] <= '0;
      end else begin
        rpt_q[i]     <= rpt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end
`else
  assign rep_hit = '0;
`endif

endmodule

// File: tb/tb_multi_edge_catcher.sv
// Directed scoreboard bench for multi_edge_catcher: rising, falling and both-edge
// instances share one stimulus; a repeat instance is added when the repeat macro is set.
module tb_multi_edge_catcher;

  localparam int unsigned CH  = 4;
  localparam int unsigned SYN = 2;
  localparam int unsigned DEB = 4;
  localparam int unsigned LAT = SYN + DEB;
`ifdef MULTI_EDGE_CATCHER_REPEAT_EN
  localparam int NDUT = 4;
`else
  localparam int NDUT = 3;
`endif
  localparam logic [3:0] M_R = 4'b0001;
  localparam logic [3:0] M_F = 4'b0010;
  localparam logic [3:0] M_B = 4'b0100;

  typedef struct {
    int unsigned cyc;
    int          dut;
    logic [3:0]  val;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_v  = '0;
  logic [3:0]  en_v  = '1;
  logic [3:0]  in_p  = '0;
  logic [3:0]  en_p  = '1;
  logic [3:0]  outs [NDUT];
  logic [3:0]  lvls [NDUT];
  logic        anys [NDUT];
  int unsigned cyc    = 0;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_edge_catcher #(.CHANNELS(CH), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0),
                       .REPEAT_DELAY(4000), .REPEAT_PERIOD(4000)) u_r (
    .clk(clk), .reset(reset), .in(in_v), .channel_en(en_v),
    .out(outs[0]), .level(lvls[0]), .any_out(anys[0]));

  multi_edge_catcher #(.CHANNELS(CH), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(1),
                       .REPEAT_DELAY(4000), .REPEAT_PERIOD(4000)) u_f (
    .clk(clk), .reset(reset), .in(in_v), .channel_en(en_v),
    .out(outs[1]), .level(lvls[1]), .any_out(anys[1]));

  multi_edge_catcher #(.CHANNELS(CH), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(2),
                       .REPEAT_DELAY(4000), .REPEAT_PERIOD(4000)) u_b (
    .clk(clk), .reset(reset), .in(in_v), .channel_en(en_v),
    .out(outs[2]), .level(lvls[2]), .any_out(anys[2]));

`ifdef MULTI_EDGE_CATCHER_REPEAT_EN
  multi_edge_catcher #(.CHANNELS(CH), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0),
                       .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) u_p (
    .clk(clk), .reset(reset), .in(in_p), .channel_en(en_p),
    .out(outs[3]), .level(lvls[3]), .any_out(anys[3]));
`endif

  task automatic at_cycle(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_exp(input int unsigned c, input logic [3:0] dmask, input logic [3:0] v);
    for (int d = 0; d < NDUT; d++) begin
      if (dmask[d]) sbq.push_back('{cyc: c, dut: d, val: v});
    end
  endtask

  task automatic check_lvl(input string tag, input logic [3:0] exp_lvl);
    for (int d = 0; d < 3; d++) begin
      checks++;
      assert (lvls[d] === exp_lvl) else begin
        errors++;
        $error("FAIL %s dut%0d cyc=%0d level observed=%b expected=%b", tag, d, cyc, lvls[d], exp_lvl);
      end
    end
  endtask

  // Every cycle each instance's out must equal the OR of the pulses queued for that cycle.
  always @(negedge clk) begin : monitor
    logic [3:0] e [NDUT];
    if (mon_en) begin
      for (int d = 0; d < NDUT; d++) e[d] = '0;
      for (int k = int'(sbq.size()) - 1; k >= 0; k--) begin
        if (sbq[k].cyc == cyc) begin
          e[sbq[k].dut] = e[sbq[k].dut] | sbq[k].val;
          sbq.delete(k);
        end
      end
      for (int d = 0; d < NDUT; d++) begin
        checks++;
        assert (outs[d] === e[d]) else begin
          errors++;
          $error("FAIL out dut%0d cyc=%0d observed=%b expected=%b", d, cyc, outs[d], e[d]);
        end
        checks++;
        assert (anys[d] === (|e[d])) else begin
          errors++;
          $error("FAIL any_out dut%0d cyc=%0d observed=%b expected=%b", d, cyc, anys[d], |e[d]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    mon_en = 1'b1;
    at_cycle(3);
    check_lvl("reset_level", 4'b0000);
    reset = 1'b0;

    // Clean press and release on ch0
    at_cycle(10);  in_v[0] = 1'b1; push_exp(10 + LAT, M_R | M_B, 4'b0001);
    at_cycle(15);  check_lvl("press_early", 4'b0000);
    at_cycle(16);  check_lvl("press_level", 4'b0001);
    at_cycle(40);  in_v[0] = 1'b0; push_exp(40 + LAT, M_F | M_B, 4'b0001);
    at_cycle(46);  check_lvl("release_level", 4'b0000);

    // Bounce on ch1; only the final settle counts
    at_cycle(60);  in_v[1] = 1'b1;
    at_cycle(62);  in_v[1] = 1'b0;
    at_cycle(64);  in_v[1] = 1'b1;
    at_cycle(66);  in_v[1] = 1'b0;
    at_cycle(68);  in_v[1] = 1'b1; push_exp(68 + LAT, M_R | M_B, 4'b0010);
    at_cycle(73);  check_lvl("bounce_early", 4'b0000);
    at_cycle(74);  check_lvl("bounce_level", 4'b0010);
    at_cycle(90);  in_v[1] = 1'b0; push_exp(90 + LAT, M_F | M_B, 4'b0010);

    // Masked press on ch2: level follows, no pulse
    at_cycle(110); en_v[2] = 1'b0; in_v[2] = 1'b1;
    at_cycle(116); check_lvl("masked_level", 4'b0100);
    at_cycle(120); en_v[2] = 1'b1;
    at_cycle(130); in_v[2] = 1'b0; push_exp(130 + LAT, M_F | M_B, 4'b0100);

    // Enable dropped right after a pulse is registered
    at_cycle(150); in_v[2] = 1'b1; push_exp(150 + LAT, M_R | M_B, 4'b0100);
    at_cycle(156); en_v[2] = 1'b0;
    at_cycle(160); en_v[2] = 1'b1;
    at_cycle(170); in_v[2] = 1'b0; push_exp(170 + LAT, M_F | M_B, 4'b0100);

    // Reset mid-press: ch0 held through reset and ch3 mid-debounce both re-accepted
    at_cycle(180); in_v[0] = 1'b1; push_exp(180 + LAT, M_R | M_B, 4'b0001);
    at_cycle(200); in_v[3] = 1'b1;
    at_cycle(203); reset = 1'b1;
    at_cycle(204); check_lvl("reset_mid", 4'b0000); reset = 1'b0;
    push_exp(204 + LAT, M_R | M_B, 4'b1001);
    at_cycle(230); in_v[0] = 1'b0; in_v[3] = 1'b0; push_exp(230 + LAT, M_F | M_B, 4'b1001);

    // All channels at once
    at_cycle(260); in_v = 4'b1111; push_exp(260 + LAT, M_R | M_B, 4'b1111);
    at_cycle(266); check_lvl("simul_level", 4'b1111);
    at_cycle(290); in_v = 4'b0000; push_exp(290 + LAT, M_F | M_B, 4'b1111);

`ifdef MULTI_EDGE_CATCHER_REPEAT_EN
    // Held input auto-repeats at +20 then every 5; released before the next slot
    at_cycle(300); in_p[0] = 1'b1;
    push_exp(306, 4'b1000, 4'b0001);
    push_exp(326, 4'b1000, 4'b0001);
    push_exp(331, 4'b1000, 4'b0001);
    push_exp(336, 4'b1000, 4'b0001);
    at_cycle(335); in_p[0] = 1'b0;
`endif

    at_cycle(380);
    mon_en = 1'b0;
    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
